// File: rtl/adpll_lock_detector_if.sv
// Signal bundle between the ADPLL loop and its lock detector.
// No valid/ready: the slave samples error_i/dco_cc_i on its internal
// ref_clk_i strobe; outputs are registered levels, lock_lost_o a one-cycle event.
interface adpll_lock_detector_if #(
  parameter int ERROR_WIDTH  = 8,
  parameter int DCO_CC_WIDTH = 5,
  parameter int COUNT_WIDTH  = 8
);
  logic                           enable_i;
  logic                           ref_clk_i;
  logic signed [ERROR_WIDTH-1:0]  error_i;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i;
  logic                           locked_o;
  logic                           lock_lost_o;
  logic [COUNT_WIDTH-1:0]         lock_time_o;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_min_o;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_max_o;
  logic [1:0]                     dbg_state_o;

  modport master (
    output enable_i, ref_clk_i, error_i, dco_cc_i,
    input  locked_o, lock_lost_o, lock_time_o, dco_cc_min_o, dco_cc_max_o, dbg_state_o
  );

  modport slave (
    input  enable_i, ref_clk_i, error_i, dco_cc_i,
    output locked_o, lock_lost_o, lock_time_o, dco_cc_min_o, dco_cc_max_o, dbg_state_o
  );
endinterface

// File: rtl/adpll_lock_detector.sv
// ADPLL lock detector: run-length lock qualification with hysteretic unlock,
// lock-time measurement and DCO control-code excursion tracking.
module adpll_lock_detector #(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 5,
  parameter int LOCK_WINDOW   = 2,
  parameter int UNLOCK_WINDOW = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  adpll_lock_detector_if.slave  bus
);
  localparam int MAG_W = ERROR_WIDTH - 1;
  localparam logic [MAG_W-1:0]       LOCK_WIN_C   = MAG_W'(LOCK_WINDOW);
  localparam logic [MAG_W-1:0]       UNLOCK_WIN_C = MAG_W'(UNLOCK_WINDOW);
  localparam logic [COUNT_WIDTH-1:0] LOCK_CNT_C   = COUNT_WIDTH'(LOCK_COUNT);
  localparam logic [COUNT_WIDTH-1:0] UNLOCK_CNT_C = COUNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE      = COUNT_WIDTH'(1);
  localparam logic [MAG_W-1:0]       MAG_ONE      = MAG_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;

  state_t                         r_state;
  logic                           r_ref_sync1, r_ref_sync2, r_ref_hist;
  logic [COUNT_WIDTH-1:0]         r_good_cnt, r_bad_cnt, r_lock_time;
  logic [COUNT_WIDTH-1:0]         r_lock_time_o;
  logic                           r_locked, r_lock_lost;
  logic signed [DCO_CC_WIDTH-1:0] r_dco_min, r_dco_max;

  logic                   w_strobe;
  logic [MAG_W-1:0]       w_err_mag;
  logic                   w_in_lock, w_miss;
  logic [COUNT_WIDTH-1:0] w_good_inc, w_bad_inc, w_ltime_inc;

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_ref_sync1 <= 1'b0;
      r_ref_sync2 <= 1'b0;
      r_ref_hist  <= 1'b0;
    end else begin
      r_ref_sync1 <= bus.ref_clk_i;
      r_ref_sync2 <= r_ref_sync1;
      r_ref_hist  <= r_ref_sync2;
    end
  end

  assign w_strobe = r_ref_sync2 & ~r_ref_hist;

  // The most negative error has no positive twin, so it clamps to full scale.
  always_comb begin
    w_err_mag = '0;
    if (bus.error_i[ERROR_WIDTH-1] && (bus.error_i[MAG_W-1:0] == '0))
      w_err_mag = '1;
    else if (bus.error_i[ERROR_WIDTH-1])
      w_err_mag = ~bus.error_i[MAG_W-1:0] + MAG_ONE;
    else
      w_err_mag = bus.error_i[MAG_W-1:0];
  end

  assign w_in_lock   = (w_err_mag <= LOCK_WIN_C);
  assign w_miss      = (w_err_mag >  UNLOCK_WIN_C);
  assign w_good_inc  = r_good_cnt + CNT_ONE;
  assign w_bad_inc   = r_bad_cnt + CNT_ONE;
  assign w_ltime_inc = (r_lock_time == '1) ? r_lock_time : r_lock_time + CNT_ONE;

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= S_IDLE;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_lock_time   <= '0;
      r_lock_time_o <= '0;
      r_locked      <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_dco_min     <= '0;
      r_dco_max     <= '0;
    end else if (!bus.enable_i) begin
      // Disable wins over a coincident strobe; hold registers keep their values.
      r_state     <= S_IDLE;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_lock_time <= '0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_ACQUIRE;
          r_good_cnt  <= '0;
          r_bad_cnt   <= '0;
          r_lock_time <= '0;
        end
        S_ACQUIRE: begin
          if (w_strobe) begin
            r_lock_time <= w_ltime_inc;
            if (w_in_lock) begin
              r_good_cnt <= w_good_inc;
              if (w_good_inc == LOCK_CNT_C) begin
                r_state       <= S_LOCKED;
                r_locked      <= 1'b1;
                r_bad_cnt     <= '0;
                r_lock_time_o <= w_ltime_inc;
                r_dco_min     <= bus.dco_cc_i;
                r_dco_max     <= bus.dco_cc_i;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_strobe) begin
            if (bus.dco_cc_i < r_dco_min) r_dco_min <= bus.dco_cc_i;
            if (bus.dco_cc_i > r_dco_max) r_dco_max <= bus.dco_cc_i;
            // Errors between the two windows leave the miss run untouched.
            if (w_miss) begin
              r_bad_cnt <= w_bad_inc;
              if (w_bad_inc == UNLOCK_CNT_C) begin
                r_state     <= S_ACQUIRE;
                r_locked    <= 1'b0;
                r_lock_lost <= 1'b1;
                r_good_cnt  <= '0;
                r_bad_cnt   <= '0;
                r_lock_time <= '0;
              end
            end else if (w_in_lock) begin
              r_bad_cnt <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.locked_o     = r_locked;
  assign bus.lock_lost_o  = r_lock_lost;
  assign bus.lock_time_o  = r_lock_time_o;
  assign bus.dco_cc_min_o = r_dco_min;
  assign bus.dco_cc_max_o = r_dco_max;
  assign bus.dbg_state_o  = r_state;
endmodule

// File: tb/tb_adpll_lock_detector.sv
// Randomized and directed bench for adpll_lock_detector with a queue-based
// scoreboard fed by a period-level behavioural model.
module tb_adpll_lock_detector;
  localparam int EW = 8;
  localparam int DW = 5;
  localparam int CW = 8;

  typedef struct packed {
    logic          locked;
    logic          lost;
    logic [CW-1:0] ltime;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
  } snap_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adpll_lock_detector_if #(.ERROR_WIDTH(EW), .DCO_CC_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  adpll_lock_detector #(
    .ERROR_WIDTH(EW), .DCO_CC_WIDTH(DW), .LOCK_WINDOW(2), .UNLOCK_WINDOW(4),
    .LOCK_COUNT(16), .UNLOCK_COUNT(4), .COUNT_WIDTH(CW)
  ) dut (
    .fpga_clk_i (clk),
    .reset_i    (rst_n),
    .bus        (bus)
  );

  // ---------------- scoreboard state ----------------
  snap_t exp_q[$];
  event  tick_ev;
  int    checks = 0;
  int    failures = 0;
  int    obs_lost = 0;
  int    exp_lost = 0;
  logic  prev_lost = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per reference period) ----------------
  int m_locked, m_good, m_bad, m_ltime, m_ltime_o, m_min, m_max, m_lost;

  task automatic model_reset();
    m_locked = 0; m_good = 0; m_bad = 0; m_ltime = 0;
    m_ltime_o = 0; m_min = 0; m_max = 0; m_lost = 0;
  endtask

  task automatic model_period(input int e, input int d);
    int mag;
    m_lost = 0;
    if (!rst_n) return;
    if (!bus.enable_i) begin
      m_locked = 0; m_good = 0; m_bad = 0; m_ltime = 0;
      return;
    end
    mag = (e < 0) ? -e : e;
    if (mag > 127) mag = 127;
    if (m_locked == 0) begin
      m_ltime = (m_ltime < 255) ? m_ltime + 1 : 255;
      if (mag <= 2) begin
        m_good++;
        if (m_good == 16) begin
          m_locked = 1; m_ltime_o = m_ltime; m_min = d; m_max = d; m_bad = 0;
        end
      end else m_good = 0;
    end else begin
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
      if (mag > 4) begin
        m_bad++;
        if (m_bad == 4) begin
          m_locked = 0; m_lost = 1; exp_lost++;
          m_good = 0; m_bad = 0; m_ltime = 0;
        end
      end else if (mag <= 2) m_bad = 0;
    end
  endtask

  function automatic snap_t model_snap(input logic lost);
    snap_t s;
    s.locked = (m_locked != 0);
    s.lost   = lost;
    s.ltime  = CW'(m_ltime_o);
    s.mn     = DW'(m_min);
    s.mx     = DW'(m_max);
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // One reference period; expected outputs are queued just before the strobe
  // takes effect and one cycle later, when the update must be visible.
  task automatic ref_period(input int err, input int dco, input logic en, input logic drop);
    int hi, lo;
    hi = int'($urandom_range(2, 4));
    lo = int'($urandom_range(2, 4));
    @(posedge clk); #1;
    bus.enable_i  = en;
    bus.error_i   = EW'(err);
    bus.dco_cc_i  = DW'(dco);
    bus.ref_clk_i = 1'b1;
    for (int c = 1; c < hi + lo; c++) begin
      @(posedge clk); #1;
      if (c == hi) bus.ref_clk_i = 1'b0;
      if (c == 2) begin
        exp_q.push_back(model_snap(1'b0));
        -> tick_ev;
        if (drop) bus.enable_i = 1'b0;
      end
      if (c == 3) begin
        model_period(err, dco);
        exp_q.push_back(model_snap(m_lost[0]));
        -> tick_ev;
      end
    end
  endtask

  task automatic repeat_err(input int n, input int err, input int dco);
    for (int i = 0; i < n; i++) ref_period(err, dco, 1'b1, 1'b0);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_snap(1'b0));
    -> tick_ev;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    snap_t a, e;
    forever begin
      @(tick_ev);
      a.locked = bus.locked_o;
      a.lost   = bus.lock_lost_o;
      a.ltime  = bus.lock_time_o;
      a.mn     = bus.dco_cc_min_o;
      a.mx     = bus.dco_cc_max_o;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("locked_o",     int'(a.locked), int'(e.locked));
        check("lock_lost_o",  int'(a.lost),   int'(e.lost));
        check("lock_time_o",  int'(a.ltime),  int'(e.ltime));
        check("dco_cc_min_o", int'(a.mn),     int'(e.mn));
        check("dco_cc_max_o", int'(a.mx),     int'(e.mx));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.lock_lost_o) begin
      obs_lost++;
      check("lost_with_locked", int'(bus.locked_o), 0);
      check("lost_width", int'(prev_lost), 0);
    end
    prev_lost = bus.lock_lost_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int mode, r, err;
    model_reset();
    bus.enable_i  = 1'b1;
    bus.ref_clk_i = 1'b0;
    bus.error_i   = '0;
    bus.dco_cc_i  = '0;

    // reset held with ref_clk_i toggling
    repeat_err(3, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // clean acquisition
    repeat_err(16, 0, 0);
    check("first_lock", int'(bus.locked_o), 1);
    check("first_lock_time", int'(bus.lock_time_o), 16);

    // hysteresis with dco sweep
    for (int i = 0; i < 50; i++) ref_period(3, -3 + (i % 11), 1'b1, 1'b0);
    repeat_err(3, -5, 0);
    repeat_err(1, 0, 0);
    repeat_err(3, -5, 0);
    check("still_locked", int'(bus.locked_o), 1);
    repeat_err(1, -5, 0);
    check("dco_min_held", int'(bus.dco_cc_min_o), -3);
    check("dco_max_held", int'(bus.dco_cc_max_o), 7);

    // run break during acquisition
    repeat_err(10, 1, 2);
    repeat_err(1, 5, 2);
    repeat_err(16, 0, 2);
    check("run_break_lock_time", int'(bus.lock_time_o), 27);

    // most negative error is a miss
    repeat_err(4, -128, 1);
    check("neg_full_scale_unlock", int'(bus.locked_o), 0);

    // lock_time saturation
    repeat_err(300, 10, 0);
    repeat_err(16, 0, -1);
    check("lock_time_saturated", int'(bus.lock_time_o), 255);

    // disable on a strobe cycle while locked, then fresh acquisition
    ref_period(0, 0, 1'b1, 1'b1);
    ref_period(0, 0, 1'b0, 1'b0);
    ref_period(0, 0, 1'b0, 1'b0);
    repeat_err(16, 0, 4);
    check("reenable_lock_time", int'(bus.lock_time_o), 16);

    // randomized blocks of quiet / marginal / noisy error
    for (int blk = 0; blk < 16; blk++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 25; i++) begin
        r = int'($urandom_range(0, 99));
        if (mode == 0)      err = (r < 96) ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 20)) - 10;
        else if (mode == 1) err = int'($urandom_range(0, 10)) - 5;
        else                err = (r < 90) ? int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 255)) - 128;
        ref_period(err, int'($urandom_range(0, 31)) - 16, 1'b1, ($urandom_range(0, 99) < 2));
      end
    end

    // async reset in the middle of acquisition
    ref_period(0, 0, 1'b1, 1'b1);
    repeat_err(5, 0, 3);
    async_reset_pulse();
    repeat_err(16, 0, 3);
    check("post_reset_lock_time", int'(bus.lock_time_o), 16);
    repeat_err(2, 1, 0);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("lost_pulse_count", obs_lost, exp_lost);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
